// File: rtl/circuito_emissor_requisicao_pkg.sv
// Shared constants for the request emitter: FSM encoding, field widths
// and the bit layout of the HH word presented to the evaluator.
package circuito_emissor_requisicao_pkg;

  localparam int ID_W   = 3;
  localparam int FUNC_W = 2;
  localparam int HH_W   = ID_W + 1;

  // HH = {ID, MODE}
  localparam int HH_ID_MSB   = 3;
  localparam int HH_ID_LSB   = 1;
  localparam int HH_MODE_BIT = 0;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_PRESENT = 2'b01;
  localparam logic [1:0] ST_HOLD    = 2'b10;
  localparam logic [1:0] ST_LOCKOUT = 2'b11;

endpackage

// File: rtl/circuito_emissor_requisicao_sincronizador_borda.sv
// 2-FF synchroniser for an asynchronous level followed by a registered
// rising-edge detector; a held level yields exactly one pulse.
module sincronizador_borda (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= d_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/circuito_emissor_requisicao.sv
// Request emitter: latches a credential/function on a send press, presents it
// for a fixed window, tracks consecutive denials and enforces a lockout.
module circuito_emissor_requisicao
  import circuito_emissor_requisicao_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000,
  parameter int LOCK_CYCLES = 250000000,
  parameter int MAX_FAILS   = 3,
  parameter int FAIL_W      = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ID_W-1:0]   sw_id_i,
  input  logic              sw_mode_i,
  input  logic [FUNC_W-1:0] sw_func_i,
  input  logic              btn_send_i,
  input  logic              grant_i,
  output logic [HH_W-1:0]   hh_o,
  output logic [FUNC_W-1:0] b_o,
  output logic              req_valid_o,
  output logic              busy_o,
  output logic              locked_o,
  output logic [FAIL_W-1:0] fail_cnt_o
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);

  logic              send;
  logic [1:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [HH_W-1:0]   hh_q,     hh_d;
  logic [FUNC_W-1:0] b_q,      b_d;
  logic              valid_q,  valid_d;
  logic              busy_q,   busy_d;
  logic              locked_q, locked_d;
  logic [FAIL_W-1:0] fail_q,   fail_d;

  sincronizador_borda u_send (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (btn_send_i),
    .pulse_o (send)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hh_d     = hh_q;
    b_d      = b_q;
    valid_d  = valid_q;
    locked_d = locked_q;
    fail_d   = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (send) begin
          hh_d[HH_ID_MSB:HH_ID_LSB] = sw_id_i;
          hh_d[HH_MODE_BIT]         = sw_mode_i;
          b_d     = sw_func_i;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // Evaluator is combinational; its answer is valid by the end of this cycle.
        if (grant_i) begin
          fail_d  = '0;
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end else if (int'(fail_q) + 1 < MAX_FAILS) begin
          fail_d  = fail_q + 1'b1;
          cnt_d   = HOLD_LOAD;
          state_d = ST_HOLD;
        end else begin
          fail_d   = FAIL_MAX;
          hh_d     = '0;
          b_d      = '0;
          valid_d  = 1'b0;
          locked_d = 1'b1;
          cnt_d    = LOCK_LOAD;
          state_d  = ST_LOCKOUT;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          hh_d    = '0;
          b_d     = '0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (cnt_q == '0) begin
          fail_d   = '0;
          locked_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hh_q     <= '0;
      b_q      <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hh_q     <= hh_d;
      b_q      <= b_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
    end
  end

  assign hh_o        = hh_q;
  assign b_o         = b_q;
  assign req_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign locked_o    = locked_q;
  assign fail_cnt_o  = fail_q;

endmodule

// File: tb/tb_circuito_emissor_requisicao.sv
// Directed bench for the request emitter with short hold/lock windows;
// outputs are packed as {HH,B,REQ_VALID,BUSY,LOCKED,FAIL_CNT}.
module tb_circuito_emissor_requisicao;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sw_id;
  logic       sw_mode;
  logic [1:0] sw_func;
  logic       btn;
  logic       grant;
  logic [3:0] hh;
  logic [1:0] b;
  logic       rv;
  logic       busy;
  logic       locked;
  logic [1:0] fail;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  circuito_emissor_requisicao #(
    .HOLD_CYCLES (4),
    .LOCK_CYCLES (8),
    .MAX_FAILS   (3),
    .FAIL_W      (2)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .sw_id_i     (sw_id),
    .sw_mode_i   (sw_mode),
    .sw_func_i   (sw_func),
    .btn_send_i  (btn),
    .grant_i     (grant),
    .hh_o        (hh),
    .b_o         (b),
    .req_valid_o (rv),
    .busy_o      (busy),
    .locked_o    (locked),
    .fail_cnt_o  (fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {21'd0, hh, b, rv, busy, locked, fail};
  endfunction

  function automatic logic [31:0] pk(input logic [3:0] h, input logic [1:0] f, input logic v,
                                     input logic bs, input logic l, input logic [1:0] fc);
    return {21'd0, h, f, v, bs, l, fc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge on which the request enters PRESENT.
  task automatic press(input logic [2:0] id, input logic m, input logic [1:0] f,
                       input logic g, input bit keep);
    sw_id = id; sw_mode = m; sw_func = f; grant = g; btn = 1'b1;
    tick();
    if (!keep) btn = 1'b0;
    tick();
    tick();
    check("no_early_valid", {31'd0, rv}, 32'd0);
    tick();
    $display("press id=%b mode=%b func=%b grant=%b -> hh=%b b=%b rv=%b fail=%0d",
             id, m, f, g, hh, b, rv, fail);
  endtask

  // Denied request that does not lock: PRESENT, then HOLD with incremented count.
  task automatic deny(input logic [1:0] exp_fail);
    press(3'b011, 1'b0, 2'b11, 1'b0, 1'b0);
    check("deny_present", outs(), pk(4'b0110, 2'b11, 1'b1, 1'b1, 1'b0, exp_fail - 2'd1));
    tick();
    check("deny_fail_cnt", outs(), pk(4'b0110, 2'b11, 1'b1, 1'b1, 1'b0, exp_fail));
    for (int i = 0; i < 4; i++) tick();
    check("deny_back_idle", outs(), pk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, exp_fail));
  endtask

  initial begin
    rst_n = 1'b0; sw_id = '0; sw_mode = 1'b0; sw_func = '0; btn = 1'b0; grant = 1'b0;
    #23;
    check("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_quiet", outs(), 32'd0);
    end

    // Granted request: 1 PRESENT + 4 HOLD cycles of valid data.
    press(3'b101, 1'b1, 2'b10, 1'b1, 1'b0);
    check("grant_present", outs(), pk(4'b1011, 2'b10, 1'b1, 1'b1, 1'b0, 2'd0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("grant_hold", outs(), pk(4'b1011, 2'b10, 1'b1, 1'b1, 1'b0, 2'd0));
    end
    tick();
    check("grant_end", outs(), 32'd0);

    // Freeze during HOLD, button held past the end of HOLD.
    tick();
    tick();
    press(3'b101, 1'b1, 2'b10, 1'b1, 1'b1);
    check("held_present", outs(), pk(4'b1011, 2'b10, 1'b1, 1'b1, 1'b0, 2'd0));
    tick();
    sw_id = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_hold", outs(), pk(4'b1011, 2'b10, 1'b1, 1'b1, 1'b0, 2'd0));
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      check("held_no_resend", outs(), 32'd0);
    end
    btn = 1'b0;
    tick();
    tick();
    tick();
    press(3'b010, 1'b0, 2'b01, 1'b1, 1'b0);
    check("repress_present", outs(), pk(4'b0100, 2'b01, 1'b1, 1'b1, 1'b0, 2'd0));
    for (int i = 0; i < 5; i++) tick();
    check("repress_end", outs(), 32'd0);

    // Three denials -> lockout for 8 cycles, presses ignored meanwhile.
    deny(2'd1);
    deny(2'd2);
    press(3'b011, 1'b0, 2'b11, 1'b0, 1'b0);
    check("lock_present", outs(), pk(4'b0110, 2'b11, 1'b1, 1'b1, 1'b0, 2'd2));
    tick();
    check("lock_enter", outs(), pk(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 2'd3));
    for (int i = 0; i < 7; i++) begin
      if (i == 0) btn = 1'b1;
      if (i == 1) btn = 1'b0;
      tick();
      check("lock_active", outs(), pk(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 2'd3));
    end
    tick();
    check("lock_exit", outs(), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lock_press_dropped", outs(), 32'd0);
    end

    // Two denials then a grant clears the count.
    deny(2'd1);
    deny(2'd2);
    press(3'b110, 1'b1, 2'b01, 1'b1, 1'b0);
    check("clr_present", outs(), pk(4'b1101, 2'b01, 1'b1, 1'b1, 1'b0, 2'd2));
    tick();
    check("clr_fail_zero", outs(), pk(4'b1101, 2'b01, 1'b1, 1'b1, 1'b0, 2'd0));
    for (int i = 0; i < 4; i++) tick();
    check("clr_end", outs(), 32'd0);

    // Asynchronous reset in the third lockout cycle.
    deny(2'd1);
    deny(2'd2);
    press(3'b011, 1'b0, 2'b11, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check("pre_reset_locked", outs(), pk(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 2'd3));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 32'd0);
    #20;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_reset_idle", outs(), 32'd0);
    press(3'b111, 1'b0, 2'b11, 1'b1, 1'b0);
    check("post_reset_press", outs(), pk(4'b1110, 2'b11, 1'b1, 1'b1, 1'b0, 2'd0));
    for (int i = 0; i < 5; i++) tick();
    check("post_reset_end", outs(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/circuito_emissor_requisicao.md
Name: circuito_emissor_requisicao

Overview:
Request-issuing front end for the dual-user access-control evaluator. It captures a user's credential (3-bit ID, 1-bit mode) and 2-bit function request from switches when a send button is pressed. It presents them as a stable HH/B word for a timed window and samples the evaluator's grant feedback. After repeated denials it enforces a lockout. One instance feeds each evaluator input pair (HH0/B0, HH1/B1).

Parameters:
HOLD_CYCLES, 50000000, cycles a presented request stays on HH/B (1 s at 50 MHz); must be >=1
LOCK_CYCLES, 250000000, lockout duration in cycles; must be >=1
MAX_FAILS, 3, consecutive denials that trigger lockout; must be >=1
FAIL_W, 2, width of FAIL_CNT; must hold MAX_FAILS

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous, active-low reset
SW_ID  in  3  user ID switches, asynchronous to CLK
SW_MODE  in  1  mode switch, asynchronous to CLK
SW_FUNC  in  2  function-request switches, asynchronous to CLK
BTN_SEND  in  1  raw send button, active-high, asynchronous to CLK
GRANT  in  1  evaluator result; 1 = permission AND function produced a nonzero code
HH  out  4  {ID[2:0], MODE} to evaluator HH input
B  out  2  function request to evaluator B input
REQ_VALID  out  1  HH/B carry a live request
BUSY  out  1  state != IDLE
LOCKED  out  1  lockout active
FAIL_CNT  out  FAIL_W  consecutive denial count

Behaviour:
- Clock and reset: one clock (CLK). RST_N is asynchronous and active-low. Assertion immediately forces all outputs to 0, state to IDLE, counters and FAIL_CNT to 0, and clears the sync/edge flops. This applies mid-HOLD and mid-LOCKOUT; a lockout does not survive reset.
- BTN_SEND passes through a 2-FF synchroniser followed by a rising-edge detector, producing a one-cycle SEND pulse. A level held high yields exactly one pulse.
- Latency: BTN_SEND stable high before CLK edge n gives SEND in cycle n+2 and REQ_VALID=1 from edge n+3.
- States (2-bit encoding): IDLE=00, PRESENT=01, HOLD=10, LOCKOUT=11.
- IDLE:
  - HH=0, B=0, REQ_VALID=0.
  - On SEND: register SW_ID, SW_MODE, SW_FUNC into HH/B, set REQ_VALID=1, go to PRESENT.
- PRESENT:
  - Lasts exactly 1 cycle; the combinational evaluator settles during it.
  - GRANT is sampled at the end of this cycle.
  - GRANT=1: FAIL_CNT<=0, go to HOLD.
  - GRANT=0 and FAIL_CNT+1 < MAX_FAILS: FAIL_CNT<=FAIL_CNT+1, go to HOLD.
  - GRANT=0 and FAIL_CNT+1 == MAX_FAILS: FAIL_CNT<=MAX_FAILS, clear HH/B, REQ_VALID<=0, LOCKED<=1, go to LOCKOUT.
- HOLD:
  - HH/B are frozen and REQ_VALID=1; switch changes have no effect.
  - Counter runs 0..HOLD_CYCLES-1, so HOLD lasts exactly HOLD_CYCLES cycles.
  - At terminal count: HH/B<=0, REQ_VALID<=0, go to IDLE.
- LOCKOUT:
  - Counter runs 0..LOCK_CYCLES-1.
  - At terminal count: FAIL_CNT<=0, LOCKED<=0, go to IDLE.
- SEND pulses in PRESENT, HOLD or LOCKOUT are discarded and not queued. A button still held on return to IDLE does not send; a new rising edge is required.
- GRANT is ignored outside PRESENT.
- A single shared down-counter serves HOLD and LOCKOUT; its width is clog2(max(HOLD_CYCLES, LOCK_CYCLES)+1). The counter is reloaded on every state entry and never wraps.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared include file holds:
  - state encoding localparams
  - ID_W=3, FUNC_W=2
  - HH field positions (ID at [3:1], MODE at [0])
- Sub-module: sincronizador_borda (2-FF synchroniser plus rising-edge pulse). It is reused later for other panel buttons.

Test Plan (HOLD_CYCLES=4, LOCK_CYCLES=8, MAX_FAILS=3):
- Reset then idle: RST_N low, then high, no button -> HH=0000, B=00, REQ_VALID=0, BUSY=0, LOCKED=0, FAIL_CNT=0 indefinitely.
- Granted request: SW_ID=101, SW_MODE=1, SW_FUNC=10, GRANT=1, pulse BTN_SEND -> REQ_VALID rises 3 cycles after press with HH=1011, B=10 for exactly 5 cycles (1 PRESENT + 4 HOLD), then back to 0; FAIL_CNT stays 0.
- Freeze and held button: during HOLD toggle SW_ID to 010 and keep BTN_SEND high past HOLD end -> HH stays 1011 throughout; no second request after returning to IDLE until the button is released and pressed again.
- Lockout: GRANT=0, three separate presses -> FAIL_CNT goes 1 then 2; on the third press LOCKED=1 for 8 cycles, REQ_VALID=0, presses ignored; then FAIL_CNT=0 and LOCKED=0.
- Fail reset by grant: deny twice (FAIL_CNT=2), then grant once -> FAIL_CNT=0, no lockout.
- Async reset mid-lockout: drop RST_N in cycle 3 of LOCKOUT, without waiting for a clock edge -> all outputs 0 immediately; after release, a press is accepted normally.
